fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Small FIFO sitting between the fetch and decode stages. Fetch pushes
// {pc, instr} pairs, decode pops them in order. A branch/jump redirect from
// decode (flush) empties the queue and drops whatever is being offered in
// that cycle.
//
// Parameters:
//   DEPTH      number of entries (power of two, >= 2)
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high reset (beats flush and handshakes)
//   in_valid   fetch presents an instruction
//   in_pc      PC of the presented instruction
//   in_instr   presented instruction word
//   in_ready   queue can accept (fetch PC write enable)
//   flush      redirect: discard all queued entries
//   out_valid  head entry available to decode
//   out_pc     PC of the head entry (0 when out_valid is low)
//   out_instr  instruction of the head entry (0 / nop when out_valid is low)
//   out_ready  decode consumes the head this cycle
//   count      number of occupied entries, 0..DEPTH
//
// Configuration macro:
//   FETCH_QUEUE_BYPASS_EN  when defined, an instruction offered to an empty
//                          queue is shown to decode in the same cycle, and
//                          passes straight through if decode takes it.
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_instr,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_instr,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_mem_pc    [DEPTH];
    logic [31:0]   r_mem_instr [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_has_entry;
    logic w_bypass;
    logic w_enq;
    logic w_deq;

    // Head is only presented when something is stored and no redirect is
    // killing it this cycle.
    assign w_has_entry = (r_count != '0) && !flush;

    // Registered-state-only ready: a dequeue while full does not open a slot
    // until the following cycle, keeping out_ready off the fetch PC path.
    assign in_ready = (r_count < CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = (r_count == '0) && in_valid && !flush;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed instruction that decode takes immediately is never stored.
    assign w_enq = in_valid && in_ready && !flush && !(w_bypass && out_ready);
    assign w_deq = w_has_entry && out_ready;

    // Output mux: stored head first, then the bypassed input, else nop (0).
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
        if (w_has_entry) begin
            out_valid = 1'b1;
            out_pc    = r_mem_pc[r_rd_ptr];
            out_instr = r_mem_instr[r_rd_ptr];
        end else if (w_bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two. Reset clears the
    // storage too; flush only needs to clear pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_mem_pc[r_wr_ptr]    <= in_pc;
                r_mem_instr[r_wr_ptr] <= in_instr;
                r_wr_ptr              <= r_wr_ptr + AW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CW'(1);
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue (DEPTH = 2). Directed scenarios cover
// reset, fill, drain order, full-with-dequeue, flush and the bypass option;
// a randomized phase compares the DUT against a queue-based model.
// Follows FETCH_QUEUE_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [1:0]  count;

    int n_checks;
    int n_fail;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (count !== 2'd0)      begin n_fail++; $display("[TB] FAIL reset_count got %0d want 0", count); end
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_out_instr got %h want 0", out_instr); end
        n_checks++; if (out_pc !== 32'h0)    begin n_fail++; $display("[TB] FAIL reset_out_pc got %h want 0", out_pc); end
        n_checks++; if (in_ready !== 1'b1)   begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_fill();
        drive(1'b1, 32'h3000, 32'h24080001, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3004, 32'h24090002, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3008, 32'h240a0003, 1'b0, 1'b0);
        n_checks++; if (count !== 2'd2)      begin n_fail++; $display("[TB] FAIL fill_count got %0d want 2", count); end
        n_checks++; if (in_ready !== 1'b0)   begin n_fail++; $display("[TB] FAIL fill_in_ready got %b want 0", in_ready); end
        n_checks++; if (out_pc !== 32'h3000) begin n_fail++; $display("[TB] FAIL fill_out_pc got %h want 3000", out_pc); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count !== 2'd2)      begin n_fail++; $display("[TB] FAIL fill_third_rejected_count got %0d want 2", count); end
        n_checks++; if (out_instr !== 32'h24080001) begin n_fail++; $display("[TB] FAIL fill_head_instr got %h want 24080001", out_instr); end
    endtask

    task automatic test_drain();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (out_pc !== 32'h3000) begin n_fail++; $display("[TB] FAIL drain_head0 got %h want 3000", out_pc); end
        tick();
        n_checks++; if (out_pc !== 32'h3004) begin n_fail++; $display("[TB] FAIL drain_head1 got %h want 3004", out_pc); end
        n_checks++; if (out_instr !== 32'h24090002) begin n_fail++; $display("[TB] FAIL drain_instr1 got %h want 24090002", out_instr); end
        tick();
        n_checks++; if (count !== 2'd0)     begin n_fail++; $display("[TB] FAIL drain_count got %0d want 0", count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_full_dequeue();
        drive(1'b1, 32'h3100, 32'h11110000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3104, 32'h11110004, 1'b0, 1'b0);
        tick();
        // Full, decode consumes and fetch offers in the same cycle.
        drive(1'b1, 32'h3108, 32'h11110008, 1'b1, 1'b0);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fulldeq_in_ready got %b want 0", in_ready); end
        tick();
        drive(1'b1, 32'h3108, 32'h11110008, 1'b0, 1'b0);
        n_checks++; if (count !== 2'd1)    begin n_fail++; $display("[TB] FAIL fulldeq_count got %0d want 1", count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fulldeq_next_ready got %b want 1", in_ready); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (count !== 2'd2)      begin n_fail++; $display("[TB] FAIL fulldeq_accept_count got %0d want 2", count); end
        n_checks++; if (out_pc !== 32'h3104) begin n_fail++; $display("[TB] FAIL fulldeq_head_b got %h want 3104", out_pc); end
        tick();
        n_checks++; if (out_pc !== 32'h3108) begin n_fail++; $display("[TB] FAIL fulldeq_head_c got %h want 3108", out_pc); end
        n_checks++; if (out_instr !== 32'h11110008) begin n_fail++; $display("[TB] FAIL fulldeq_instr_c got %h want 11110008", out_instr); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count !== 2'd0) begin n_fail++; $display("[TB] FAIL fulldeq_empty got %0d want 0", count); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h3200, 32'h22220000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3204, 32'h22220004, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3008, 32'h33330008, 1'b0, 1'b1);
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("[TB] FAIL flush_cycle_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_pc !== 32'h0)    begin n_fail++; $display("[TB] FAIL flush_cycle_out_pc got %h want 0", out_pc); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count !== 2'd0)     begin n_fail++; $display("[TB] FAIL flush_count got %0d want 0", count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_out_valid got %b want 0", out_valid); end
        drive(1'b1, 32'h3300, 32'h44440000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (out_pc !== 32'h3300) begin n_fail++; $display("[TB] FAIL flush_refill_head got %h want 3300", out_pc); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_bypass();
        drive(1'b1, 32'h3010, 32'h55550010, 1'b1, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        n_checks++; if (out_valid !== 1'b1)  begin n_fail++; $display("[TB] FAIL bypass_out_valid got %b want 1", out_valid); end
        n_checks++; if (out_pc !== 32'h3010) begin n_fail++; $display("[TB] FAIL bypass_out_pc got %h want 3010", out_pc); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count !== 2'd0)      begin n_fail++; $display("[TB] FAIL bypass_count got %0d want 0", count); end
`else
        n_checks++; if (out_valid !== 1'b0)  begin n_fail++; $display("[TB] FAIL nobypass_same_cycle got %b want 0", out_valid); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b1)  begin n_fail++; $display("[TB] FAIL nobypass_next_valid got %b want 1", out_valid); end
        n_checks++; if (out_pc !== 32'h3010) begin n_fail++; $display("[TB] FAIL nobypass_next_pc got %h want 3010", out_pc); end
        n_checks++; if (count !== 2'd1)      begin n_fail++; $display("[TB] FAIL nobypass_count got %0d want 1", count); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`endif
    endtask

    // Reference model: a plain queue of {pc, instr}; expectations come from
    // the queue length and its front element.
    task automatic test_random();
        logic [63:0] q[$];
        logic        v, ordy, fl, rst;
        logic [31:0] pc, ins;
        logic        exp_ready, exp_valid, byp;
        logic [31:0] exp_pc, exp_instr;
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            rst  = ($urandom_range(0, 63) == 0);
            pc   = $urandom;
            ins  = $urandom;
            reset = rst;
            drive(v, pc, ins, ordy, fl);
            exp_ready = (q.size() < DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
            byp = (q.size() == 0) && v && !fl;
`else
            byp = 1'b0;
`endif
            exp_valid = 1'b0;
            exp_pc    = 32'h0;
            exp_instr = 32'h0;
            if (q.size() != 0 && !fl) begin
                exp_valid = 1'b1;
                exp_pc    = q[0][63:32];
                exp_instr = q[0][31:0];
            end else if (byp) begin
                exp_valid = 1'b1;
                exp_pc    = pc;
                exp_instr = ins;
            end
            n_checks++; if (count !== 2'(q.size())) begin n_fail++; $display("[TB] FAIL rand_count cyc %0d got %0d want %0d", cyc, count, q.size()); end
            n_checks++; if (in_ready !== exp_ready) begin n_fail++; $display("[TB] FAIL rand_in_ready cyc %0d got %b want %b", cyc, in_ready, exp_ready); end
            n_checks++; if (out_valid !== exp_valid) begin n_fail++; $display("[TB] FAIL rand_out_valid cyc %0d got %b want %b", cyc, out_valid, exp_valid); end
            n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("[TB] FAIL rand_out_pc cyc %0d got %h want %h", cyc, out_pc, exp_pc); end
            n_checks++; if (out_instr !== exp_instr) begin n_fail++; $display("[TB] FAIL rand_out_instr cyc %0d got %h want %h", cyc, out_instr, exp_instr); end
            tick();
            if (rst || fl) begin
                q.delete();
            end else if (!(byp && ordy)) begin
                if (q.size() != 0 && ordy) void'(q.pop_front());
                if (v && exp_ready) q.push_back({pc, ins});
            end
        end
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_pc    = '0;
        in_instr = '0;
        out_ready = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_drain();
        test_full_dequeue();
        test_flush();
        test_bypass();
        test_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
